// File: rtl/booth_pkg.sv
// Radix-4 Booth digit select codes and the digit-to-select mapping
// shared by the partial-product generators.
package booth_pkg;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG2 = 3'd3,
    NEG1 = 3'd4
  } booth_sel_t;

  // Approximate mode folds the +/-2x digits onto +/-x.
  function automatic booth_sel_t booth_sel(input logic [2:0] digit, input logic approx);
    booth_sel_t sel;
    sel = ZERO;
    case (digit)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = approx ? POS1 : POS2;
      3'b100:         sel = approx ? NEG1 : NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product (WIDTH+2 bits) for a single digit,
// plus a flag telling whether approximation altered that digit.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [2:0]       digit,
  input  logic             approx,
  output logic [WIDTH+1:0] pp,
  output logic             hit
);

  logic [WIDTH+1:0] x1;
  logic [WIDTH+1:0] x2;

  // Two guard bits let -2x of the most negative x stay representable.
  assign x1 = {{2{x[WIDTH-1]}}, x};
  assign x2 = {x1[WIDTH:0], 1'b0};

  always_comb begin
    pp = '0;
    case (booth_sel(digit, approx))
      POS1:    pp = x1;
      POS2:    pp = x2;
      NEG1:    pp = -x1;
      NEG2:    pp = -x2;
      default: pp = '0;
    endcase
  end

  assign hit = approx && ((digit == 3'b011) || (digit == 3'b100));

endmodule

// File: rtl/booth_approx_pipe.sv
// Three-stage radix-4 Booth multiplier with optional approximate digits
// and a valid/ready handshake driven by a single pipeline enable.
module booth_approx_pipe
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_hit
);

  localparam int N = WIDTH / 2;

  logic               enable;

  logic               s1_valid_reg;
  logic [WIDTH-1:0]   s1_x_reg;
  logic [WIDTH-1:0]   s1_y_reg;
  logic               s1_approx_reg;

  logic               s2_valid_reg;
  logic [WIDTH+1:0]   s2_pp_reg [N];
  logic               s2_hit_reg;

  logic               s3_valid_reg;
  logic [2*WIDTH-1:0] s3_p_reg;
  logic               s3_hit_reg;

  logic [WIDTH+1:0]   pp_next [N];
  logic [N-1:0]       hit_vec;
  logic [2*WIDTH-1:0] sum_next;

  // A stalled output freezes everything; an empty output lets bubbles collapse.
  assign enable   = out_ready || !s3_valid_reg;
  assign in_ready = enable;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pp
      logic [2:0] digit;
      if (gi == 0) begin : g_first
        assign digit = {s1_y_reg[1:0], 1'b0};
      end else begin : g_rest
        assign digit = s1_y_reg[2*gi+1 -: 3];
      end
      booth_pp_gen #(.WIDTH(WIDTH)) u_pp (
        .x      (s1_x_reg),
        .digit  (digit),
        .approx (s1_approx_reg),
        .pp     (pp_next[gi]),
        .hit    (hit_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < N; k++) begin
      sum_next = sum_next + ({{(WIDTH-2){s2_pp_reg[k][WIDTH+1]}}, s2_pp_reg[k]} << (2*k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_x_reg      <= '0;
      s1_y_reg      <= '0;
      s1_approx_reg <= 1'b0;
      s2_valid_reg  <= 1'b0;
      for (int k = 0; k < N; k++) s2_pp_reg[k] <= '0;
      s2_hit_reg    <= 1'b0;
      s3_valid_reg  <= 1'b0;
      s3_p_reg      <= '0;
      s3_hit_reg    <= 1'b0;
    end else if (enable) begin
      s1_valid_reg  <= in_valid;
      s1_x_reg      <= in_x;
      s1_y_reg      <= in_y;
      s1_approx_reg <= in_approx;
      s2_valid_reg  <= s1_valid_reg;
      for (int k = 0; k < N; k++) s2_pp_reg[k] <= pp_next[k];
      s2_hit_reg    <= |hit_vec;
      s3_valid_reg  <= s2_valid_reg;
      s3_p_reg      <= sum_next;
      s3_hit_reg    <= s2_hit_reg;
    end
  end

  assign out_valid = s3_valid_reg;
  assign out_p     = s3_p_reg;
  assign out_hit   = s3_hit_reg;

endmodule

// File: tb/tb_booth_approx_pipe.sv
// Randomised and directed checks of booth_approx_pipe against a digit-level
// arithmetic reference model and a FIFO scoreboard.
module tb_booth_approx_pipe;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic           in_approx;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           out_hit;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2*W-1:0] p;
    logic           h;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  booth_approx_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_approx (in_approx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_hit   (out_hit)
  );

  // Each digit is worth -2*b2 + b1 + b0; approximation halves +/-2 digits.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic a);
    exp_t e;
    int sx, sum, d, b2, b1, b0;
    logic h;
    sx  = int'($signed(x));
    sum = 0;
    h   = 1'b0;
    for (int k = 0; k < W/2; k++) begin
      b2 = int'(y[2*k+1]);
      b1 = int'(y[2*k]);
      b0 = (k == 0) ? 0 : int'(y[2*k-1]);
      d  = -2*b2 + b1 + b0;
      if (a && (d == 2 || d == -2)) begin
        d = d / 2;
        h = 1'b1;
      end
      sum = sum + d * sx * (1 << (2*k));
    end
    e.p = sum[2*W-1:0];
    e.h = h;
    return e;
  endfunction

  // Drives one cycle of inputs at the falling edge and reports which
  // handshakes will fire on the following rising edge.
  task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic a, input logic r, output logic fin, output logic fout);
    @(negedge clk);
    in_valid  = v;
    in_x      = x;
    in_y      = y;
    in_approx = a;
    out_ready = r;
    #1;
    fin  = in_valid && in_ready;
    fout = out_valid && out_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: out_valid=%b expected 0", out_valid);
    end
    tests++;
    if (out_p !== '0 || out_hit !== 1'b0) begin
      fails++;
      $display("FAIL reset_data: out_p=%h out_hit=%b expected 0000/0", out_p, out_hit);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: in_ready=%b expected 1", in_ready);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_directed();
    logic [W-1:0]   xs [9] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'h80, 8'h80, 8'd7, 8'd0, 8'h7F};
    logic [W-1:0]   ys [9] = '{8'd3, 8'd3, 8'd2, 8'd2, 8'h80, 8'h80, 8'hFF, 8'h55, 8'h7F};
    logic           as [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2*W-1:0] ps [9] = '{16'h000F, 16'h000F, 16'h000A, 16'h000F, 16'h4000, 16'h2000,
                               16'hFFF9, 16'h0000, 16'h3F01};
    logic           hs [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic fin, fout;
    exp_t e;
    int idx = 0;
    for (int c = 0; c < 40 && (idx < 9 || q.size() > 0); c++) begin
      if (idx < 9) step(1'b1, xs[idx], ys[idx], as[idx], 1'b1, fin, fout);
      else         step(1'b0, '0, '0, 1'b0, 1'b1, fin, fout);
      if (fout) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL directed_spurious: out_p=%h with nothing expected", out_p);
        end else begin
          e = q.pop_front();
          if (out_p !== e.p || out_hit !== e.h) begin
            fails++;
            $display("FAIL directed: out_p=%h out_hit=%b expected %h/%b", out_p, out_hit, e.p, e.h);
          end
        end
      end
      if (fin) begin
        e.p = ps[idx];
        e.h = hs[idx];
        q.push_back(e);
        $display("[TB] directed x=%h y=%h approx=%b expect %h/%b", xs[idx], ys[idx], as[idx], e.p, e.h);
        idx++;
      end
    end
    tests++;
    if (idx != 9 || q.size() != 0) begin
      fails++;
      $display("FAIL directed_timeout: accepted=%0d pending=%0d expected 9/0", idx, q.size());
    end
    q.delete();
  endtask

  task automatic test_exhaustive();
    logic fin, fout;
    exp_t e;
    int i = 0;
    int bad = 0;
    int prod;
    for (int c = 0; c < 65600 && (i < 65536 || q.size() > 0); c++) begin
      if (i < 65536) step(1'b1, i[15:8], i[7:0], 1'b0, 1'b1, fin, fout);
      else           step(1'b0, '0, '0, 1'b0, 1'b1, fin, fout);
      if (fout) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          bad++;
          $display("FAIL exhaustive_spurious: out_p=%h with nothing expected", out_p);
        end else begin
          e = q.pop_front();
          if (out_p !== e.p || out_hit !== e.h) begin
            fails++;
            bad++;
            if (bad <= 10)
              $display("FAIL exhaustive: out_p=%h out_hit=%b expected %h/%b", out_p, out_hit, e.p, e.h);
          end
        end
      end
      if (fin) begin
        prod = int'($signed(i[15:8])) * int'($signed(i[7:0]));
        e.p  = prod[2*W-1:0];
        e.h  = 1'b0;
        q.push_back(e);
        i++;
      end
    end
    tests++;
    if (i != 65536 || q.size() != 0) begin
      fails++;
      $display("FAIL exhaustive_timeout: accepted=%0d pending=%0d expected 65536/0", i, q.size());
    end
    $display("[TB] exhaustive exact sweep: %0d mismatching products", bad);
    q.delete();
  endtask

  task automatic test_random();
    logic fin, fout;
    logic [W-1:0] x, y;
    logic a, v, r;
    exp_t e;
    int sent = 0;
    for (int c = 0; c < 600 && (sent < 300 || q.size() > 0); c++) begin
      x = W'($urandom);
      y = W'($urandom);
      a = 1'($urandom);
      v = (sent < 300) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0) || (sent >= 300);
      step(v, x, y, a, r, fin, fout);
      if (fout) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL random_spurious: out_p=%h with nothing expected", out_p);
        end else begin
          e = q.pop_front();
          if (out_p !== e.p || out_hit !== e.h) begin
            fails++;
            $display("FAIL random: out_p=%h out_hit=%b expected %h/%b", out_p, out_hit, e.p, e.h);
          end
        end
      end
      if (fin) begin
        q.push_back(model(x, y, a));
        sent++;
      end
    end
    tests++;
    if (sent != 300 || q.size() != 0) begin
      fails++;
      $display("FAIL random_timeout: accepted=%0d pending=%0d expected 300/0", sent, q.size());
    end
    $display("[TB] random mixed-mode stream of %0d transactions done", sent);
    q.delete();
  endtask

  task automatic test_backpressure();
    logic fin, fout;
    logic [W-1:0] x, y;
    logic a, r;
    logic [2*W-1:0] held_p;
    logic held_h;
    exp_t e;
    int sent = 0;
    int got = 0;
    for (int c = 0; c < 60 && (sent < 6 || q.size() > 0); c++) begin
      x = W'(8'd11 + 8'(c * 23));
      y = W'($urandom);
      a = c[0];
      r = !(c >= 4 && c < 8);
      step(sent < 6, x, y, a, r, fin, fout);
      if (c >= 4 && c < 8) begin
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
          fails++;
          $display("FAIL bp_stall c=%0d: out_valid=%b in_ready=%b expected 1/0", c, out_valid, in_ready);
        end
        if (c == 4) begin
          held_p = out_p;
          held_h = out_hit;
        end else begin
          tests++;
          if (out_p !== held_p || out_hit !== held_h) begin
            fails++;
            $display("FAIL bp_stable c=%0d: out_p=%h/%b expected %h/%b", c, out_p, out_hit, held_p, held_h);
          end
        end
      end
      if (fout) begin
        tests++;
        got++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL bp_spurious: out_p=%h with nothing expected", out_p);
        end else begin
          e = q.pop_front();
          if (out_p !== e.p || out_hit !== e.h) begin
            fails++;
            $display("FAIL bp_order: out_p=%h out_hit=%b expected %h/%b", out_p, out_hit, e.p, e.h);
          end
        end
      end
      if (fin) begin
        q.push_back(model(x, y, a));
        sent++;
      end
    end
    tests++;
    if (sent != 6 || got != 6 || q.size() != 0) begin
      fails++;
      $display("FAIL bp_count: sent=%0d delivered=%0d expected 6/6", sent, got);
    end
    $display("[TB] backpressure stream: sent=%0d delivered=%0d", sent, got);
    q.delete();
  endtask

  task automatic test_reset_inflight();
    logic fin, fout;
    int seen = 0;
    step(1'b1, 8'd9, 8'd9, 1'b0, 1'b1, fin, fout);
    step(1'b1, 8'd3, 8'd4, 1'b1, 1'b1, fin, fout);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_p !== '0 || out_hit !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: out_valid=%b out_p=%h out_hit=%b expected 0/0000/0", out_valid, out_p, out_hit);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_ready: in_ready=%b expected 1", in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, fin, fout);
      if (out_valid) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rst_discard: out_valid seen %0d cycles expected 0", seen);
    end
    step(1'b1, 8'd5, 8'd2, 1'b1, 1'b1, fin, fout);
    tests++;
    if (fin !== 1'b1) begin
      fails++;
      $display("FAIL rst_transfer: accepted=%b expected 1", fin);
    end
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, fin, fout);
      tests++;
      if (out_valid !== (c == 3)) begin
        fails++;
        $display("FAIL rst_latency edge=%0d: out_valid=%b expected %b", c, out_valid, (c == 3));
      end
    end
    tests++;
    if (out_p !== 16'h000F || out_hit !== 1'b1) begin
      fails++;
      $display("FAIL rst_result: out_p=%h out_hit=%b expected 000f/1", out_p, out_hit);
    end
    $display("[TB] reset with transactions in flight checked");
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_approx = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_inflight();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
